qsub_seq: RTL and testbench
===========================

QSUB_SEQ -- requirements
Module: qsub_seq

Interface
REQ-001 SHALL have parameter Q, default 16: fractional bit count of the sign-magnitude operands. It is documentation only and does not affect the datapath.
REQ-002 SHALL have parameter N, default 32: total word width; bit N-1 is the sign and bits N-2:0 are the magnitude.
REQ-003 SHALL have parameter D, default 8: digit width processed per cycle; K = ceil((N-1)/D).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: operands a and b are valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts operands.
REQ-008 SHALL have port a, input, N bits: minuend, sign-magnitude.
REQ-009 SHALL have port b, input, N bits: subtrahend, sign-magnitude.
REQ-010 SHALL have port out_valid, output, 1 bit: c and ovf are valid.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port c, output, N bits: a - b in sign-magnitude.
REQ-013 SHALL have port ovf, output, 1 bit: magnitude overflow occurred.

Function
REQ-014 SHALL compute c = a - b as a + (-b): invert the sign of b, then apply sign-magnitude addition.
REQ-015 Equal effective signs: magnitude SHALL be |a| + |b|, and sign SHALL be the sign of a.
REQ-016 Differing effective signs: magnitude SHALL be the larger magnitude minus the smaller; sign SHALL be that of the operand with the larger magnitude; if magnitudes are equal, the result is zero.
REQ-017 A zero result magnitude SHALL always produce sign 0; negative zero is never output.
REQ-018 SHALL zero-extend magnitudes to K*D bits internally and use only bits N-2:0 of the result.
REQ-019 FSM states SHALL be IDLE, CMP, ARITH and DONE.
REQ-020 in_ready SHALL equal (state==IDLE && !rst).
REQ-021 in_valid && in_ready on an edge SHALL register a and b and enter CMP.
REQ-022 CMP SHALL compare magnitudes one digit per cycle, most-significant digit first, for exactly K cycles regardless of signs.
REQ-023 ARITH SHALL add or subtract one digit per cycle, least-significant digit first, with a registered carry/borrow, for exactly K cycles; the FSM then enters DONE.
REQ-024 out_valid SHALL be high exactly in DONE, 2K cycles after the capture edge (8 cycles for the defaults).
REQ-025 c and ovf SHALL remain stable while out_valid=1 && out_ready=0.
REQ-026 out_valid && out_ready on an edge SHALL return the FSM to IDLE; the next capture is possible one cycle later.
REQ-027 in_valid asserted outside IDLE SHALL be ignored, and the operands SHALL not be sampled.
REQ-028 ovf SHALL be 1 only when equal effective signs produce a carry out of magnitude bit N-2; subtraction never sets ovf.
REQ-029 Without saturation, an overflowed magnitude SHALL wrap to its low N-1 bits, and the sign SHALL still follow REQ-015/REQ-017.

Reset
REQ-030 rst assertion SHALL immediately force state IDLE, out_valid=0, c=0, ovf=0 and in_ready=0, discarding any operation in progress.
REQ-031 in_ready SHALL rise with rst deassertion; the first capture is possible on the following edge.

Configuration
REQ-032 Macro QSUB_SAT_EN defined: on overflow, the magnitude SHALL saturate to all ones, the sign SHALL follow REQ-015, and ovf=1.
REQ-033 Macro QSUB_SAT_EN undefined: on overflow, the magnitude SHALL wrap per REQ-029 and ovf=1; there is no saturation logic.

Verification (N=32, Q=16, D=8)
REQ-034 a=0x00030000, b=0x00010000 -> c=0x00020000, ovf=0, out_valid 8 cycles after capture.
REQ-035 a=0x00010000, b=0x00030000 -> c=0x80020000; a=0x80018000, b=0x00028000 -> c=0x80040000.
REQ-036 a=b=0x00050000 -> c=0x00000000; a=b=0x80050000 -> c=0x00000000, with sign bit 0 in both cases.
REQ-037 a=0x7FFF0000, b=0x80020000 -> ovf=1; c=0x00010000 without QSUB_SAT_EN, c=0x7FFFFFFF with it.
REQ-038 out_ready held 0 for 5 cycles in DONE -> c stable and in_ready=0 throughout; a new in_valid is ignored.
REQ-039 rst pulsed during ARITH -> out_valid=0 and c=0 immediately; the next operation returns the correct result at 8-cycle latency.

Source files
------------

// File: rtl/qsub_seq.sv
// Digit-serial sign-magnitude subtractor: c = a - b, D bits per cycle, K compare + K arithmetic cycles.
// Optional saturation on magnitude overflow when QSUB_SAT_EN is defined (default: wrap).
module qsub_seq #(
  parameter int Q = 16,
  parameter int N = 32,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         ovf
);

  // Q only documents the fixed-point format; it never reaches the datapath.
  localparam int K  = ((N - 1 + D - 1) / D) + 0 * Q;
  localparam int W  = K * D;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CMP   = 2'd1;
  localparam logic [1:0] S_ARITH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_a_mag, r_b_mag, r_res;
  logic          r_sa, r_sb, r_gt, r_lt, r_carry;
  logic [N-1:0]  r_c;
  logic          r_ovf;

  logic          w_last, w_add, w_gt_nxt, w_lt_nxt, w_ovf, w_sign;
  logic [D-1:0]  w_a_top, w_b_top;
  logic [W-1:0]  w_a_rotl, w_b_rotl, w_a_rotr, w_b_rotr, w_res_nxt;
  logic [D:0]    w_ad, w_bd, w_cin, w_dsum;
  logic [W:0]    w_full;
  logic [N-2:0]  w_mag;

  assign w_last = (r_cnt == CW'(K - 1));
  assign w_add  = (r_sa == r_sb);

  // Compare walks MSB digit first by rotating left; K rotations restore the words.
  assign w_a_top  = r_a_mag[W-1 -: D];
  assign w_b_top  = r_b_mag[W-1 -: D];
  assign w_a_rotl = W'({r_a_mag, r_a_mag} >> (W - D));
  assign w_b_rotl = W'({r_b_mag, r_b_mag} >> (W - D));
  assign w_gt_nxt = r_gt | (!r_lt && (w_a_top > w_b_top));
  assign w_lt_nxt = r_lt | (!r_gt && (w_a_top < w_b_top));

  // Arithmetic walks LSB digit first; the larger magnitude always sits in r_a_mag.
  assign w_a_rotr  = W'({r_a_mag, r_a_mag} >> D);
  assign w_b_rotr  = W'({r_b_mag, r_b_mag} >> D);
  assign w_ad      = {1'b0, r_a_mag[D-1:0]};
  assign w_bd      = {1'b0, r_b_mag[D-1:0]};
  assign w_cin     = {{D{1'b0}}, r_carry};
  assign w_dsum    = w_add ? (w_ad + w_bd + w_cin) : (w_ad - w_bd - w_cin);
  assign w_res_nxt = W'({w_dsum[D-1:0], r_res} >> D);

  // Any bit at or above N-1 means a carry left the magnitude field.
  assign w_full = {w_dsum[D], w_res_nxt};
  assign w_ovf  = w_add && (|w_full[W:N-1]);

`ifdef QSUB_SAT_EN
  assign w_mag = w_ovf ? {(N-1){1'b1}} : w_full[N-2:0];
`else
  assign w_mag = w_full[N-2:0];
`endif

  assign w_sign = ((!w_add && r_lt) ? r_sb : r_sa) && (w_mag != '0);

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = (r_state == S_DONE);
  assign c         = r_c;
  assign ovf       = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a_mag <= '0;
      r_b_mag <= '0;
      r_res   <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
      r_carry <= 1'b0;
      r_c     <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a_mag <= W'(a[N-2:0]);
            r_b_mag <= W'(b[N-2:0]);
            r_sa    <= a[N-1];
            r_sb    <= ~b[N-1];
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
            r_carry <= 1'b0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_state <= S_CMP;
          end
        end
        S_CMP: begin
          r_gt <= w_gt_nxt;
          r_lt <= w_lt_nxt;
          if (w_last) begin
            r_a_mag <= w_lt_nxt ? w_b_rotl : w_a_rotl;
            r_b_mag <= w_lt_nxt ? w_a_rotl : w_b_rotl;
            r_cnt   <= '0;
            r_state <= S_ARITH;
          end else begin
            r_a_mag <= w_a_rotl;
            r_b_mag <= w_b_rotl;
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        S_ARITH: begin
          r_a_mag <= w_a_rotr;
          r_b_mag <= w_b_rotr;
          r_res   <= w_res_nxt;
          r_carry <= w_dsum[D];
          if (w_last) begin
            r_c     <= {w_sign, w_mag};
            r_ovf   <= w_ovf;
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qsub_seq.sv
// Bench for qsub_seq: directed vectors plus random operands against a signed-integer reference model.
module tb_qsub_seq;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, ovf;
  logic [N-1:0] a, b, c;
  int           n_cmp = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  qsub_seq #(.Q(16), .N(N), .D(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .ovf(ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: treat operands as signed integers, subtract, then re-encode.
  function automatic void model(input logic [31:0] ia, input logic [31:0] ib,
                                output logic [31:0] rc, output logic rovf);
    longint ma, mb, va, vb, d, m;
    ma = longint'(ia[30:0]);
    mb = longint'(ib[30:0]);
    va = ia[31] ? -ma : ma;
    vb = ib[31] ? -mb : mb;
    d  = va - vb;
    m  = (d < 0) ? -d : d;
    rovf = (m > 64'h7FFF_FFFF);
    if (rovf) begin
`ifdef QSUB_SAT_EN
      m = 64'h7FFF_FFFF;
`else
      m = m & 64'h7FFF_FFFF;
`endif
    end
    rc = {((d < 0) && (m != 0)), m[30:0]};
  endfunction

  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input int hold,
                        output logic [31:0] oc, output logic oovf);
    logic [31:0] ec, c0;
    logic        eovf, o0;
    int          lat;
    model(ia, ib, ec, eovf);
    lat = 0;
    while (!in_ready && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("in_ready_idle", in_ready, 1);
    a = ia; b = ib; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("in_ready_busy", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("latency", lat, 8);
    chk("c", c, ec);
    chk("ovf", ovf, eovf);
    c0 = c; o0 = ovf;
    for (int i = 0; i < hold; i++) begin
      a = $urandom; b = $urandom; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_c", c, c0);
      chk("hold_ovf", ovf, o0);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
    oc = c0; oovf = o0;
  endtask

  initial begin
    logic [31:0] oc, ra, rb;
    logic        oo;
    int          sel;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_c", c, 0);
    chk("rst_ovf", ovf, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", in_ready, 1);

    run_op(32'h0003_0000, 32'h0001_0000, 0, oc, oo);
    chk("dir_basic_c", oc, 32'h0002_0000); chk("dir_basic_ovf", oo, 0);
    run_op(32'h0001_0000, 32'h0003_0000, 0, oc, oo);
    chk("dir_neg_c", oc, 32'h8002_0000);
    run_op(32'h8001_8000, 32'h0002_8000, 0, oc, oo);
    chk("dir_negadd_c", oc, 32'h8004_0000);
    run_op(32'h0005_0000, 32'h0005_0000, 0, oc, oo);
    chk("dir_zero_pos_c", oc, 32'h0000_0000);
    run_op(32'h8005_0000, 32'h8005_0000, 0, oc, oo);
    chk("dir_zero_neg_c", oc, 32'h0000_0000);
    run_op(32'h7FFF_0000, 32'h8002_0000, 0, oc, oo);
    chk("dir_ovf_flag", oo, 1);
`ifdef QSUB_SAT_EN
    chk("dir_ovf_c", oc, 32'h7FFF_FFFF);
`else
    chk("dir_ovf_c", oc, 32'h0001_0000);
`endif
    run_op(32'h0012_3456, 32'h8000_1111, 5, oc, oo);
    chk("dir_hold_c", oc, 32'h0012_4567);

    // Abort an operation mid-arithmetic; the held previous result must clear.
    a = 32'h0040_0000; b = 32'h0010_0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_c", c, 32'h0012_4567);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_c", c, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_in_ready", in_ready, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    run_op(32'h0040_0000, 32'h0010_0000, 0, oc, oo);
    chk("post_rst_c", oc, 32'h0030_0000);

    for (int n = 0; n < 40; n++) begin
      ra = $urandom; rb = $urandom;
      sel = $urandom_range(0, 3);
      if (sel == 0) rb = {rb[31], ra[30:0]};
      else if (sel == 1) begin ra[30] = 1'b1; rb[30] = 1'b1; end
      else if (sel == 2) begin ra = ra & 32'h8000_FFFF; rb = rb & 32'h8000_FFFF; end
      run_op(ra, rb, $urandom_range(0, 2), oc, oo);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
